aer_encoder: RTL and testbench

//   Converts a multi-hot event vector (e.g. one spike bit per neuron) into a

---
 rtl/aer_encoder.sv | 126 ++++++++++++
 tb/tb_aer_encoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_encoder.sv
// aer_encoder: turns a multi-hot event vector into a stream of binary indices,
// lowest index first, one index per accepted output beat. Valid/ready on both
// the vector input and the index output. A new vector can be loaded on the
// same cycle the final index of the current vector is accepted, so
// back-to-back vectors stream without a bubble.
module aer_encoder #(
  parameter int WIDTH = 16,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;

  logic             in_hs;
  logic             out_hs;
  logic             in_nonzero;

  // Index of the lowest set bit; returns 0 for an all-zero vector so that the
  // index output rests at 0 while idle.
  function automatic logic [IDX_W-1:0] lowest_index(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Drop the lowest set bit (v & (v - 1)).
  function automatic logic [WIDTH-1:0] clear_lowest(input logic [WIDTH-1:0] v);
    return v & (v - WIDTH'(1'b1));
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_single(input logic [WIDTH-1:0] v);
    return (v != {WIDTH{1'b0}}) && (clear_lowest(v) == {WIDTH{1'b0}});
  endfunction

  // Output decode and handshakes; everything here is derived from the
  // registered state and pending vector, plus the live ready/valid inputs.
  always_comb begin
    out_valid  = (state_q == ST_SCAN);
    busy       = (state_q == ST_SCAN);
    out_idx    = lowest_index(pending_q);
    out_last   = (state_q == ST_SCAN) && is_single(pending_q);
    out_hs     = out_valid && out_ready;
    in_ready   = (state_q == ST_IDLE) || (out_hs && out_last);
    in_hs      = in_valid && in_ready;
    in_nonzero = (in_vec != {WIDTH{1'b0}});
  end

  // Next-state logic: load a vector, retire one bit per accepted index, and
  // either reload or drain to idle when the last bit is accepted.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (in_hs && in_nonzero) begin
          pending_d = in_vec;
          state_d   = ST_SCAN;
        end else begin
          // An all-zero vector is consumed without emitting anything.
          pending_d = {WIDTH{1'b0}};
          state_d   = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (out_hs && !out_last) begin
          pending_d = clear_lowest(pending_q);
          state_d   = ST_SCAN;
        end else if (out_hs && out_last) begin
          if (in_hs && in_nonzero) begin
            pending_d = in_vec;
            state_d   = ST_SCAN;
          end else begin
            pending_d = {WIDTH{1'b0}};
            state_d   = ST_IDLE;
          end
        end else begin
          // Stalled: index, last flag and pending vector hold.
          pending_d = pending_q;
          state_d   = ST_SCAN;
        end
      end
      default: begin
        pending_d = {WIDTH{1'b0}};
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and pending-vector registers; reset discards any remaining indices.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_aer_encoder.sv
// Self-checking bench for aer_encoder (WIDTH = 16). Inputs are driven 1 time
// unit after the rising edge and outputs are sampled 2 time units after it.
module tb_aer_encoder;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  int checks;
  int errors;

  typedef struct {
    int idx;
    bit last;
  } ev_t;

  aer_encoder #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_vec   (in_vec),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_idx  (out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Move to the drive point of the next cycle.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Move from the drive point to the sample point of the same cycle.
  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
    next_cycle();
    reset = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL post_reset valid=%0b ready=%0b exp 0/1", out_valid, in_ready); end
    next_cycle();
  endtask

  task automatic test_zero_vector();
    in_vec = 16'h0000; in_valid = 1'b1; out_ready = 1'b1;
    settle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready got=%0b exp=1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL zero_idle cyc=%0d valid=%0b busy=%0b ready=%0b exp 0/0/1", c, out_valid, busy, in_ready);
      end
      next_cycle();
    end
  endtask

  task automatic test_sparse();
    int exp_idx [4] = '{0, 5, 10, 15};
    in_vec = 16'h8421; in_valid = 1'b1; out_ready = 1'b1;
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sparse_latency got=%0b exp=0", out_valid); end
    next_cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if (out_valid !== 1'b1 || out_idx !== IDX_W'(exp_idx[k]) || out_last !== (k == 3)) begin
        errors++; $display("FAIL sparse_beat k=%0d valid=%0b idx=%0d last=%0b exp 1/%0d/%0b", k, out_valid, out_idx, out_last, exp_idx[k], (k == 3));
      end
      next_cycle();
    end
    settle();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL sparse_done busy=%0b valid=%0b exp 0/0", busy, out_valid); end
    next_cycle();
  endtask

  task automatic test_stall();
    in_vec = 16'h0003; in_valid = 1'b1; out_ready = 1'b0;
    next_cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_last !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc=%0d valid=%0b idx=%0d last=%0b exp 1/0/0", c, out_valid, out_idx, out_last);
      end
      next_cycle();
    end
    out_ready = 1'b1;
    settle();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_last !== 1'b0) begin errors++; $display("FAIL stall_first idx=%0d last=%0b exp 0/0", out_idx, out_last); end
    next_cycle();
    settle();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd1 || out_last !== 1'b1) begin errors++; $display("FAIL stall_second idx=%0d last=%0b exp 1/1", out_idx, out_last); end
    next_cycle();
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_done valid=%0b exp 0", out_valid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    in_vec = 16'h0010; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_vec = 16'h0101; in_valid = 1'b1;
    settle();
    checks++; if (out_idx !== 4'd4 || out_last !== 1'b1) begin errors++; $display("FAIL b2b_first idx=%0d last=%0b exp 4/1", out_idx, out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%0b exp=1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_last !== 1'b0) begin errors++; $display("FAIL b2b_second valid=%0b idx=%0d last=%0b exp 1/0/0", out_valid, out_idx, out_last); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_not_ready got=%0b exp=0", in_ready); end
    next_cycle();
    settle();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd8 || out_last !== 1'b1) begin errors++; $display("FAIL b2b_third valid=%0b idx=%0d last=%0b exp 1/8/1", out_valid, out_idx, out_last); end
    next_cycle();
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done valid=%0b exp 0", out_valid); end
    next_cycle();
  endtask

  task automatic test_top_bit();
    in_vec = 16'h8000; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd15 || out_last !== 1'b1) begin errors++; $display("FAIL top_bit valid=%0b idx=%0d last=%0b exp 1/15/1", out_valid, out_idx, out_last); end
    next_cycle();
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL top_bit_done valid=%0b exp 0", out_valid); end
    next_cycle();
  endtask

  task automatic test_all_ones_random_ready();
    int  seen;
    bit  prev_stall;
    int  prev_idx;
    bit  done;
    seen = 0; prev_stall = 1'b0; prev_idx = 0; done = 1'b0;
    in_vec = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b0;
    next_cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      out_ready = ($urandom_range(0, 99) < 55);
      settle();
      if (prev_stall) begin
        checks++; if (out_idx !== IDX_W'(prev_idx)) begin errors++; $display("FAIL ones_stall_hold idx=%0d exp=%0d", out_idx, prev_idx); end
      end
      if (out_valid && out_ready) begin
        checks++; if (out_idx !== IDX_W'(seen) || out_last !== (seen == WIDTH - 1)) begin
          errors++; $display("FAIL ones_order idx=%0d last=%0b exp %0d/%0b", out_idx, out_last, seen, (seen == WIDTH - 1));
        end
        seen++;
        if (seen == WIDTH) done = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_idx   = int'(out_idx);
      next_cycle();
    end
    out_ready = 1'b1;
    settle();
    checks++; if (seen != WIDTH || out_valid !== 1'b0) begin errors++; $display("FAIL ones_count seen=%0d valid=%0b exp %0d/0", seen, out_valid, WIDTH); end
    next_cycle();
  endtask

  task automatic test_reset_mid_stream();
    in_vec = 16'h00F0; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    settle();
    checks++; if (out_idx !== 4'd4) begin errors++; $display("FAIL midrst_idx4 got=%0d exp=4", out_idx); end
    next_cycle();
    settle();
    checks++; if (out_idx !== 4'd5) begin errors++; $display("FAIL midrst_idx5 got=%0d exp=5", out_idx); end
    next_cycle();
    reset = 1'b1;
    settle();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_immediate valid=%0b busy=%0b ready=%0b exp 0/0/1", out_valid, busy, in_ready);
    end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after cyc=%0d valid=%0b exp 0", c, out_valid); end
      next_cycle();
    end
  endtask

  // Random vectors, random valid gaps and random backpressure against a queue
  // model: the queue holds every index still owed to the consumer.
  task automatic test_random();
    ev_t              q[$];
    int               sent;
    bit               offer;
    logic [WIDTH-1:0] offer_vec;
    bit               exp_valid;
    bit               exp_in_ready;
    int               cnt;
    int               n;
    bit               finished;
    sent = 0; offer = 1'b0; offer_vec = '0; finished = 1'b0;
    for (int c = 0; c < 3000 && !finished; c++) begin
      if (!offer && sent < 40 && $urandom_range(0, 3) != 0) begin
        offer = 1'b1;
        case ($urandom_range(0, 4))
          0:       offer_vec = 16'h0000;
          1:       offer_vec = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
          2:       offer_vec = WIDTH'(16'h0001) << $urandom_range(0, WIDTH - 1);
          default: offer_vec = WIDTH'($urandom);
        endcase
      end
      in_valid  = offer;
      in_vec    = offer ? offer_vec : WIDTH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      exp_valid    = (q.size() != 0);
      exp_in_ready = (q.size() == 0) || (out_ready && q.size() == 1);
      checks++; if (out_valid !== exp_valid || busy !== exp_valid || in_ready !== exp_in_ready) begin
        errors++; $display("FAIL rand_ctrl cyc=%0d valid=%0b busy=%0b ready=%0b exp %0b/%0b/%0b", c, out_valid, busy, in_ready, exp_valid, exp_valid, exp_in_ready);
      end
      if (exp_valid) begin
        checks++; if (out_idx !== IDX_W'(q[0].idx) || out_last !== q[0].last) begin
          errors++; $display("FAIL rand_data cyc=%0d idx=%0d last=%0b exp %0d/%0b", c, out_idx, out_last, q[0].idx, q[0].last);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (offer && exp_in_ready) begin
        cnt = 0;
        for (int i = 0; i < WIDTH; i++) if (offer_vec[i]) cnt++;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
          if (offer_vec[i]) begin
            n++;
            q.push_back('{idx: i, last: (n == cnt)});
          end
        end
        offer = 1'b0;
        sent++;
      end
      if (sent == 40 && !offer && q.size() == 0) finished = 1'b1;
      next_cycle();
    end
    in_valid = 1'b0;
    checks++; if (!finished) begin errors++; $display("FAIL rand_timeout sent=%0d owed=%0d exp 40/0", sent, q.size()); end
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; in_vec = '0; in_valid = 1'b0; out_ready = 1'b0;
    checks = 0; errors = 0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_zero_vector();
    test_sparse();
    test_stall();
    test_back_to_back();
    test_top_bit();
    test_all_ones_random_ready();
    test_reset_mid_stream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
